selector_nch_rr: RTL and testbench

- Parametrised N-channel, W-bit selector; successor to the fixed 4:1 combinational selector.
- Adds a per-channel valid/ready handshake and a registered output stage.
- Two selection modes: software-fixed channel select, or round-robin arbitration among valid channels.
- Sits between multiple producer datapaths and a single downstream consumer; one grant per cycle.

---
 rtl/sel_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/selector_nch_rr.sv | 91 +++++++++
 tb/tb_selector_nch_rr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared constants, mode encodings and round-robin pick helper
package sel_pkg;
    localparam int MAX_CHANNELS = 16;
    localparam int MAX_SEL_W    = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or above ptr, wrapping at channels-1 back to 0.
    function automatic rr_pick_t rr_pick(input logic [MAX_CHANNELS-1:0] valid,
                                         input logic [MAX_SEL_W-1:0]    ptr,
                                         input int                      channels);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 0; k < MAX_CHANNELS; k++) begin
            idx = (int'(ptr) + k) % channels;
            if (k < channels && !pick.found && valid[idx]) begin
                pick.found = 1'b1;
                pick.idx   = MAX_SEL_W'(idx);
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter
    import sel_pkg::*;
#(
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                enable,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);
    logic [MAX_CHANNELS-1:0] w_valid_ext;
    logic [MAX_SEL_W-1:0]    w_ptr_ext;
    rr_pick_t                w_pick;

    always_comb begin
        w_valid_ext                 = '0;
        w_valid_ext[CHANNELS-1:0]   = valid;
        w_ptr_ext                   = '0;
        w_ptr_ext[SEL_W-1:0]        = ptr;
        w_pick                      = rr_pick(w_valid_ext, w_ptr_ext, CHANNELS);
        grant                       = '0;
        for (int i = 0; i < CHANNELS; i++)
            grant[i] = enable && w_pick.found && (w_pick.idx == MAX_SEL_W'(i));
        grant_idx = w_pick.idx[SEL_W-1:0];
    end
endmodule

// File: rtl/selector_nch_rr.sv
// rtl/selector_nch_rr.sv - N-channel selector, fixed or round-robin, registered output
module selector_nch_rr
    import sel_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  WIDTH    = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] number_bus,
    input  logic [CHANNELS-1:0]       number_valid,
    output logic [CHANNELS-1:0]       number_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          result,
    output logic [SEL_W-1:0]          result_channel,
    output logic                      result_valid,
    input  logic                      result_ready
);
    logic [WIDTH-1:0]    r_result;
    logic [SEL_W-1:0]    r_result_channel;
    logic                r_result_valid;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_can_load;
    logic                w_rr_enable;
    logic                w_transfer;
    logic [CHANNELS-1:0] w_fix_grant;
    logic [CHANNELS-1:0] w_rr_grant;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_rr_idx;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [SEL_W-1:0]    w_next_ptr;
    logic [WIDTH-1:0]    w_data;

    assign w_can_load  = !r_result_valid || result_ready;
    assign w_rr_enable = (mode == MODE_RR) && w_can_load;

    // An out-of-range select matches no channel index, so it never grants.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_fix_grant[i] = (mode == MODE_FIXED) && w_can_load && number_valid[i]
                             && (select == SEL_W'(i));
    end

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
        .valid     (number_valid),
        .ptr       (r_rr_ptr),
        .enable    (w_rr_enable),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    assign w_grant      = w_fix_grant | w_rr_grant;
    assign w_grant_idx  = (mode == MODE_RR) ? w_rr_idx : select;
    assign w_transfer   = |w_grant;
    assign w_next_ptr   = (w_grant_idx == SEL_W'(CHANNELS-1)) ? '0 : w_grant_idx + SEL_W'(1);
    assign number_ready = rst ? '0 : w_grant;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (w_grant[i])
                w_data = number_bus[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result         <= '0;
            r_result_channel <= '0;
            r_result_valid   <= 1'b0;
            r_rr_ptr         <= '0;
        end else begin
            if (w_transfer) begin
                r_result         <= w_data;
                r_result_channel <= w_grant_idx;
                r_result_valid   <= 1'b1;
            end else if (result_ready) begin
                r_result_valid   <= 1'b0;
            end
            if (w_transfer && mode == MODE_RR)
                r_rr_ptr <= w_next_ptr;
        end
    end

    assign result         = r_result;
    assign result_channel = r_result_channel;
    assign result_valid   = r_result_valid;
endmodule

// File: tb/tb_selector_nch_rr.sv
// tb/tb_selector_nch_rr.sv - self-checking bench for selector_nch_rr
module tb_selector_nch_rr;
    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] bus;
    logic [N-1:0]  nvalid;
    logic [N-1:0]  nready;
    logic          mode;
    logic [1:0]    sel;
    logic [W-1:0]  result;
    logic [1:0]    rch;
    logic          rvalid;
    logic          rready;

    selector_nch_rr #(.CHANNELS(N), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .number_bus     (bus),
        .number_valid   (nvalid),
        .number_ready   (nready),
        .mode           (mode),
        .select         (sel),
        .result         (result),
        .result_channel (rch),
        .result_valid   (rvalid),
        .result_ready   (rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       md;
        logic [1:0] sl;
        logic [3:0] v;
        logic       rr;
        logic [3:0] e_ready;
        logic       e_valid;
        logic [7:0] e_res;
        logic [1:0] e_ch;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic md, input logic [1:0] sl, input logic [3:0] v,
                                input logic rr, input logic [3:0] e_ready, input logic e_valid,
                                input logic [7:0] e_res, input logic [1:0] e_ch);
        vec_t t;
        t.md = md; t.sl = sl; t.v = v; t.rr = rr;
        t.e_ready = e_ready; t.e_valid = e_valid; t.e_res = e_res; t.e_ch = e_ch;
        return t;
    endfunction

    task automatic drive(input logic md, input logic [1:0] sl, input logic [3:0] v, input logic rr);
        mode = md; sel = sl; nvalid = v; rready = rr;
    endtask

    // Reference model: output register contents plus round-robin pointer.
    logic       m_valid;
    logic [7:0] m_res;
    int         m_ch;
    int         m_ptr;

    function automatic int model_grant(input logic md, input logic [1:0] sl,
                                       input logic [3:0] v, input logic rr);
        int g = -1;
        if (m_valid && !rr) return -1;
        if (!md) begin
            if (int'(sl) < N && v[sl]) g = int'(sl);
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        return g;
    endfunction

    initial begin
        // Fixed select 2, then unreachable target, round-robin fairness, skip/wrap, backpressure.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 2, 4'hF, 1, 4'b0100, 1, 8'h33, 2));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 4'b1101, 1, 4'b0000, 0, 8'h33, 2));
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0));
            vecs.push_back(mk(1, 0, 4'hF, 1, 4'b0010, 1, 8'h22, 1));
            vecs.push_back(mk(1, 0, 4'hF, 1, 4'b0100, 1, 8'h33, 2));
            vecs.push_back(mk(1, 0, 4'hF, 1, 4'b1000, 1, 8'h44, 3));
        end
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b0001, 1, 8'h11, 0));
            vecs.push_back(mk(1, 0, 4'b1001, 1, 4'b1000, 1, 8'h44, 3));
        end
        vecs.push_back(mk(1, 0, 4'b0001, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk(1, 0, 4'b0100, 1, 4'b0100, 1, 8'h33, 2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 4'hF, 0, 4'b0000, 1, 8'h33, 2));
        vecs.push_back(mk(1, 0, 4'hF, 1, 4'b1000, 1, 8'h44, 3));
        vecs.push_back(mk(1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 4'b0000, 0, 8'h11, 0));
        vecs.push_back(mk(0, 3, 4'hF, 0, 4'b1000, 1, 8'h44, 3));
        vecs.push_back(mk(1, 0, 4'hF, 0, 4'b0000, 1, 8'h44, 3));

        bus = 32'h4433_2211;
        rst = 1'b1;
        drive(0, 0, 4'hF, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", rvalid, 0);
        check("reset_result", result, 0);
        check("reset_chan", rch, 0);
        check("reset_ready", nready, 0);

        rst = 1'b0;
        #1;
        check("release_ready", nready, 4'b0001);
        @(posedge clk); #1;
        check("release_valid", rvalid, 1);
        check("release_result", result, 8'h11);
        check("release_chan", rch, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", nready, 0);
            @(posedge clk); #1;
            check("hold_valid", rvalid, 1);
            check("hold_result", result, 8'h11);
            check("hold_chan", rch, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].md, vecs[i].sl, vecs[i].v, vecs[i].rr);
            #1;
            check($sformatf("vec%0d_ready", i), nready, vecs[i].e_ready);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), rvalid, vecs[i].e_valid);
            check($sformatf("vec%0d_result", i), result, vecs[i].e_res);
            check($sformatf("vec%0d_chan", i), rch, vecs[i].e_ch);
        end

        // Reset arriving mid-cycle with a transfer pending clears the register at once.
        drive(1, 0, 4'hF, 1);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", rvalid, 0);
        check("midrst_result", result, 0);
        check("midrst_ready", nready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 1'b0; m_res = '0; m_ch = 0; m_ptr = 0;

        for (int c = 0; c < 400; c++) begin
            logic       md;
            logic [1:0] sl;
            logic [3:0] v;
            logic       rr;
            int         g;
            bus = $urandom;
            md  = 1'($urandom_range(0, 1));
            sl  = 2'($urandom_range(0, 3));
            v   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 3) != 0);
            drive(md, sl, v, rr);
            #1;
            g = model_grant(md, sl, v, rr);
            check("rnd_ready", nready, (g >= 0) ? (32'd1 << g) : 32'd0);
            @(posedge clk);
            if (g >= 0) begin
                m_res   = bus[g*W +: W];
                m_ch    = g;
                m_valid = 1'b1;
                if (md) m_ptr = (g + 1) % N;
            end else if (rr) begin
                m_valid = 1'b0;
            end
            #1;
            check("rnd_valid", rvalid, m_valid);
            check("rnd_result", result, m_res);
            check("rnd_chan", rch, m_ch);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
